regfile_sync: RTL and testbench
===============================

REGFILE_SYNC -- requirements
Module: regfile_sync

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter ZERO_REG, default 1; when 1, entry 0 is hardwired to zero.
REQ-004 SHALL have port clk, input, 1, single clock, all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have port clr, input, 1, synchronous soft-clear request.
REQ-007 SHALL have port wr_en, input, 1, write strobe.
REQ-008 SHALL have port wr_addr, input, ADDR_W, write address.
REQ-009 SHALL have port wr_data, input, DATA_W, write data.
REQ-010 SHALL have ports rd_addr1 and rd_addr2, input, ADDR_W each, read addresses.
REQ-011 SHALL have ports rd_data1 and rd_data2, output, DATA_W each, registered read data.
REQ-012 SHALL have port ready, output, 1, high when the array is initialised and accepting writes.

Function
REQ-013 SHALL implement a two-state FSM: CLEAR (sweeping entries to zero) and RUN (normal operation).
REQ-014 In CLEAR, SHALL write zero to entry clr_ptr each cycle and increment clr_ptr; at clr_ptr == DEPTH-1, SHALL move to RUN on the next edge.
REQ-015 SHALL assert ready only in RUN; ready rises exactly DEPTH cycles after rst deasserts.
REQ-016 In CLEAR, SHALL ignore wr_en and drive rd_data1/rd_data2 to zero.
REQ-017 In RUN, wr_en=1 SHALL write wr_data to entry wr_addr at the rising edge.
REQ-018 With ZERO_REG=1, writes to address 0 SHALL be discarded and reads of address 0 SHALL return zero.
REQ-019 Reads SHALL have one-cycle latency: rd_dataN at edge k+1 reflects rd_addrN sampled at edge k.
REQ-020 Both read ports SHALL be independent; identical addresses on both ports SHALL return identical data.
REQ-021 clr=1 in RUN SHALL return the FSM to CLEAR with clr_ptr=0 and deassert ready on the next edge; any write in that same cycle SHALL be discarded.
REQ-022 clr=1 in CLEAR SHALL restart the sweep at clr_ptr=0.
REQ-023 Addresses SHALL wrap naturally within ADDR_W bits; no out-of-range case exists.

Reset
REQ-024 rst=1 SHALL immediately force state=CLEAR, clr_ptr=0, ready=0, rd_data1=rd_data2=0, regardless of clk.
REQ-025 Array contents SHALL NOT be reset directly; zeroing is done by the CLEAR sweep.
REQ-026 rst asserted mid-sweep or mid-write SHALL abort that operation; the sweep restarts from entry 0 after release.

Configuration
REQ-027 Macro REGFILE_SYNC_BYPASS_EN SHALL control write-to-read forwarding.
REQ-028 With REGFILE_SYNC_BYPASS_EN defined, a RUN-state read whose address equals wr_addr while wr_en=1 (address nonzero or ZERO_REG=0) SHALL return the new wr_data next cycle.
REQ-029 Without REGFILE_SYNC_BYPASS_EN, that same read SHALL return the old stored value; the new value is visible one cycle later.

Structure
REQ-030 A shared package regfile_pkg SHALL hold the FSM state typedef (CLEAR, RUN) and default DATA_W/ADDR_W constants.
REQ-031 The storage array SHALL be a sub-module regfile_mem (one write port, two synchronous read ports); FSM, bypass and zero-register logic stay in regfile_sync.

Verification
REQ-032 Release rst, DEPTH=32 -> ready=0 for 32 cycles, then 1; reading any address returns 0.
REQ-033 Write 64 to r10, 31 to r14, 45 to r19; then read r10/r14, then r19/r0 -> rd_data 0x40/0x1F, then 0x2D/0x0.
REQ-034 Write 0xDEADBEEF to r0 with ZERO_REG=1 -> subsequent read of r0 returns 0.
REQ-035 Write 0x55 to r7 while reading r7 (old value 0x11) -> bypass build returns 0x55 next cycle; non-bypass build returns 0x11, then 0x55.
REQ-036 Assert clr for one cycle in RUN after writing r10=64 -> ready drops next edge, returns after 32 cycles, r10 reads 0.
REQ-037 Assert rst asynchronously mid-sweep (clr_ptr=12) -> outputs zero immediately; ready rises 32 cycles after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the synchronous register file.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

endpackage

// File: rtl/regfile_mem.sv
// Storage array: one write port and two registered read ports, no reset on contents.
module regfile_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Reads see the pre-write contents when read and write addresses collide.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata1 <= mem[raddr1];
        rdata2 <= mem[raddr2];
    end

endmodule

// File: rtl/regfile_sync.sv
// Two-read/one-write register file with a zeroing sweep after reset or clr.
// Define REGFILE_SYNC_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_sync
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              ready
);

    localparam int                DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH-1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] clr_ptr, clr_ptr_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_n;
            clr_ptr <= clr_ptr_n;
        end
    end

    always_comb begin
        state_n   = state;
        clr_ptr_n = clr_ptr;
        case (state)
            CLEAR: begin
                if (clr) begin
                    clr_ptr_n = '0;
                end else if (clr_ptr == LAST) begin
                    state_n   = RUN;
                    clr_ptr_n = '0;
                end else begin
                    clr_ptr_n = clr_ptr + 1'b1;
                end
            end
            RUN: begin
                if (clr) begin
                    state_n   = CLEAR;
                    clr_ptr_n = '0;
                end
            end
            default: state_n = CLEAR;
        endcase
    end

    assign ready = (state == RUN);

    logic run_ok, wr_zero, wr_ok;
    assign run_ok  = (state == RUN) && !clr;
    assign wr_zero = (ZERO_REG != 0) && (wr_addr == '0);
    assign wr_ok   = run_ok && wr_en && !wr_zero;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    assign mem_we    = (state == CLEAR) || wr_ok;
    assign mem_waddr = (state == CLEAR) ? clr_ptr : wr_addr;
    assign mem_wdata = (state == CLEAR) ? '0 : wr_data;

    logic [1:0][ADDR_W-1:0] raddr;
    logic [1:0][DATA_W-1:0] mem_rdata, rd_out;
    assign raddr = {rd_addr2, rd_addr1};

    regfile_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
        .clk    (clk),
        .we     (mem_we),
        .waddr  (mem_waddr),
        .wdata  (mem_wdata),
        .raddr1 (raddr[0]),
        .raddr2 (raddr[1]),
        .rdata1 (mem_rdata[0]),
        .rdata2 (mem_rdata[1])
    );

    // Per-port force-zero flag, registered alongside the array read so it
    // lines up with mem_rdata; resetting it to 1 zeroes outputs immediately.
    logic [1:0] zero_n, zero_q;
    always_comb begin
        for (int i = 0; i < 2; i++)
            zero_n[i] = !run_ok || ((ZERO_REG != 0) && (raddr[i] == '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) zero_q <= '1;
        else     zero_q <= zero_n;
    end

`ifdef REGFILE_SYNC_BYPASS_EN
    logic [1:0]        byp_n, byp_q;
    logic [DATA_W-1:0] byp_data_q;
    always_comb begin
        for (int i = 0; i < 2; i++)
            byp_n[i] = wr_ok && (raddr[i] == wr_addr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp_q      <= '0;
            byp_data_q <= '0;
        end else begin
            byp_q      <= byp_n;
            byp_data_q <= wr_data;
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++)
            rd_out[i] = zero_q[i] ? '0 : (byp_q[i] ? byp_data_q : mem_rdata[i]);
    end
`else
    always_comb begin
        for (int i = 0; i < 2; i++)
            rd_out[i] = zero_q[i] ? '0 : mem_rdata[i];
    end
`endif

    assign rd_data1 = rd_out[0];
    assign rd_data2 = rd_out[1];

endmodule

// File: tb/tb_regfile_sync.sv
// Scoreboard bench for regfile_sync: reads push expected data, a monitor checks it.
module tb_regfile_sync;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [AW-1:0] rd_addr1 = '0;
    logic [AW-1:0] rd_addr2 = '0;
    logic [DW-1:0] rd_data1, rd_data2;
    logic          ready;

    regfile_sync #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            tag;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic rd_req = 1'b0;
    logic done = 1'b0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a read on both ports; the expected pair goes to the scoreboard.
    task automatic rd(input int tag, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                      input logic [DW-1:0] e1, input logic [DW-1:0] e2);
        exp_t e;
        e.tag = tag; e.e1 = e1; e.e2 = e2;
        rd_addr1 = a1;
        rd_addr2 = a2;
        rd_req   = 1'b1;
        sb.push_back(e);
        step();
        rd_req = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    // Count edges from now until ready rises, bounded.
    task automatic count_ready(input string nm);
        int n = 0;
        while (!ready && n < 100) begin
            step();
            n++;
        end
        chk(nm, DW'(n), DW'(32));
    endtask

    // Monitor: a request seen at an edge is compared on the following negedge.
    initial begin
        logic p;
        exp_t e;
        forever begin
            @(posedge clk);
            p = rd_req;
            @(negedge clk);
            if (p) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard_empty: got read response expected none");
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("rd1_tag%0d", e.tag), rd_data1, e.e1);
                    chk($sformatf("rd2_tag%0d", e.tag), rd_data2, e.e2);
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] byp_exp;
`ifdef REGFILE_SYNC_BYPASS_EN
        byp_exp = 32'h55;
`else
        byp_exp = 32'h11;
`endif
        #12;
        chk("reset_ready", DW'(ready), '0);
        chk("reset_rd1", rd_data1, '0);
        chk("reset_rd2", rd_data2, '0);

        @(posedge clk); #1;
        rst = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hFFFF_FFFF;  // ignored in CLEAR
        step();
        wr_en = 1'b0;
        chk("sweep_ready_low", DW'(ready), '0);
        chk("sweep_rd_zero", rd_data1 | rd_data2, '0);
        begin
            int n = 1;
            while (!ready && n < 100) begin step(); n++; end
            chk("release_to_ready", DW'(n), DW'(32));
        end

        rd(1, 5'd5, 5'd31, 32'h0, 32'h0);
        rd(2, 5'd9, 5'd0, 32'h0, 32'h0);

        wr(5'd10, 32'd64);
        wr(5'd14, 32'd31);
        wr(5'd19, 32'd45);
        rd(3, 5'd10, 5'd14, 32'h40, 32'h1F);
        rd(4, 5'd19, 5'd0, 32'h2D, 32'h0);

        wr(5'd0, 32'hDEAD_BEEF);
        rd(5, 5'd0, 5'd0, 32'h0, 32'h0);

        wr(5'd7, 32'h11);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
        rd(6, 5'd7, 5'd10, byp_exp, 32'd64);
        wr_en = 1'b0;
        rd(7, 5'd7, 5'd7, 32'h55, 32'h55);

        // Async reset while RUN outputs are nonzero.
        rd(8, 5'd7, 5'd19, 32'h55, 32'h2D);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("async_rst_ready", DW'(ready), '0);
        chk("async_rst_rd1", rd_data1, '0);
        chk("async_rst_rd2", rd_data2, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        count_ready("run_rst_to_ready");
        rd(9, 5'd7, 5'd19, 32'h0, 32'h0);

        // Soft clear with a colliding write that must be dropped.
        wr(5'd10, 32'd64);
        rd(10, 5'd10, 5'd10, 32'd64, 32'd64);
        clr = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h99;
        step();
        clr = 1'b0; wr_en = 1'b0;
        chk("clr_ready_drop", DW'(ready), '0);
        count_ready("clr_to_ready");
        rd(11, 5'd10, 5'd3, 32'h0, 32'h0);

        // Reset mid-sweep at clr_ptr = 12.
        wr(5'd12, 32'h1234);
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (12) step();
        #2;
        rst = 1'b1;
        #1;
        chk("midsweep_rst_ready", DW'(ready), '0);
        chk("midsweep_rst_rd", rd_data1 | rd_data2, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        count_ready("midsweep_to_ready");
        rd(12, 5'd12, 5'd31, 32'h0, 32'h0);

        step();
        step();
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
        end
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        if (!done) begin
            $display("FAIL timeout: got no completion expected finish");
            errors++;
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $fatal(1);
        end
    end

endmodule
